// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default constants for the UART receive sequencer.
//   uart_state_t   - receive FSM state encoding
//   OVERSAMPLE_DEF - default sample ticks per bit
//   MID_SAMPLE_DEF - default sample count at which the start bit is validated
//   SC_W           - default sample-counter width
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      PARITY,
      RECOVER
   } uart_state_t;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int MID_SAMPLE_DEF = OVERSAMPLE_DEF / 2 - 1;
   localparam int SC_W           = $clog2(OVERSAMPLE_DEF);

endpackage

// File: rtl/uart_sample_counter.sv
// uart_sample_counter: wrapping oversample counter, log2(OVERSAMPLE) bits wide.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   clr  - synchronous clear, wins over tick
//   tick - count enable (one pulse per oversample tick)
//   cnt  - current count, wraps OVERSAMPLE-1 -> 0
//   tc   - terminal count (cnt == OVERSAMPLE-1)
module uart_sample_counter
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int W          = $clog2(OVERSAMPLE)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         tick,
   output logic [W-1:0] cnt,
   output logic         tc
);

   assign tc = (cnt == W'(OVERSAMPLE - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= tc ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer: 16x-oversampled UART receive controller.
// Finds the start bit, samples each data bit at mid-bit (LSB first), checks the
// stop bit and delivers a byte with a one-clock valid strobe.
// Optional build macro: UART_RX_PARITY_EN adds an even-parity bit before stop.
// Ports:
//   clk         - system clock
//   rst         - synchronous active-high reset
//   sample_tick - one-clock enable at OVERSAMPLE x baud
//   rx_in       - synchronised serial line, idle high
//   rx_data     - last good byte, held until the next good frame
//   rx_valid    - one-clock pulse when rx_data updates
//   rx_busy     - high whenever the FSM is not IDLE
//   frame_err   - sticky bad-stop flag, cleared by the next good frame
//   parity_err  - sticky parity flag (constant 0 without UART_RX_PARITY_EN)
//
// state   | meaning
// IDLE    | line idle, waiting for a low sample
// START   | counting to mid start bit to reject glitches
// DATA    | sampling data bits once per bit period
// PARITY  | sampling the parity bit (parity build only)
// STOP    | sampling the stop bit, delivering the byte
// RECOVER | bad stop seen, waiting for the line to return high
module uart_rx_sequencer
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int MID_SAMPLE = MID_SAMPLE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sample_tick,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_busy,
   output logic                 frame_err,
   output logic                 parity_err
);

   localparam int SCW = $clog2(OVERSAMPLE);
   localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   uart_state_t          state_q, state_d;
   logic [SCW-1:0]       sc;
   logic                 sc_tc;
   logic                 sc_clr;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 shift_en;
   logic                 last_bit;
   logic                 stop_good;
   logic                 stop_bad;
   logic                 deliver;

   uart_sample_counter #(.OVERSAMPLE(OVERSAMPLE), .W(SCW)) u_sc (
      .clk  (clk),
      .rst  (rst),
      .clr  (sc_clr),
      .tick (sample_tick),
      .cnt  (sc),
      .tc   (sc_tc)
   );

   assign last_bit = (bit_idx == BW'(DATA_BITS - 1));
   assign rx_busy  = (state_q != IDLE);

`ifdef UART_RX_PARITY_EN
   logic par_smp;
   logic par_bad;
`endif

   always_comb begin
      state_d   = state_q;
      sc_clr    = 1'b0;
      shift_en  = 1'b0;
      stop_good = 1'b0;
      stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_smp   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            // Counter held at 0 so the start tick becomes t0.
            sc_clr = 1'b1;
            if (sample_tick && !rx_in) state_d = START;
         end
         START: begin
            if (sample_tick && (sc == SCW'(MID_SAMPLE))) begin
               sc_clr  = 1'b1;
               state_d = rx_in ? IDLE : DATA;
            end
         end
         DATA: begin
            if (sample_tick && sc_tc) begin
               shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
               if (last_bit) state_d = PARITY;
`else
               if (last_bit) state_d = STOP;
`endif
            end
         end
         PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (sample_tick && sc_tc) begin
               par_smp = 1'b1;
               state_d = STOP;
            end
`else
            state_d = IDLE;
`endif
         end
         STOP: begin
            if (sample_tick && sc_tc) begin
               if (rx_in) begin
                  stop_good = 1'b1;
                  state_d   = IDLE;
               end else begin
                  stop_bad  = 1'b1;
                  state_d   = RECOVER;
               end
            end
         end
         RECOVER: begin
            // A held-low line (break) must not look like a new start.
            sc_clr = 1'b1;
            if (sample_tick && rx_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef UART_RX_PARITY_EN
   assign deliver = stop_good && !par_bad;

   always_ff @(posedge clk) begin
      if (rst) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         // Even parity: data bits plus parity bit must XOR to 0.
         if (par_smp)   par_bad    <= (rx_in != ^shift);
         if (stop_good) parity_err <= par_bad;
         if (stop_bad)  parity_err <= parity_err | par_bad;
      end
   end
`else
   assign deliver    = stop_good;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_idx   <= '0;
         shift     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state_q  <= state_d;
         rx_valid <= 1'b0;
         if (shift_en) begin
            shift   <= {rx_in, shift[DATA_BITS-1:1]};
            bit_idx <= last_bit ? '0 : bit_idx + BW'(1);
         end else if (state_q != DATA) begin
            bit_idx <= '0;
         end
         if (deliver) begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
         end
         if (stop_good) frame_err <= 1'b0;
         if (stop_bad)  frame_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
module tb_uart_rx_sequencer;

`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_TICKS = FRAME_BITS * 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_tick;
   logic       rx_in;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;
   logic       parity_err;

   int checks = 0;
   int errors = 0;
   int tick_cnt = 0;
   int valid_cnt = 0;
   int last_tick = 0;

   uart_rx_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (sample_tick),
      .rx_in       (rx_in),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_busy     (rx_busy),
      .frame_err   (frame_err),
      .parity_err  (parity_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (sample_tick) tick_cnt++;

   always @(negedge clk) begin
      if (rx_valid) begin
         valid_cnt++;
         last_tick = tick_cnt;
      end
   end

   initial begin
      #10ms;
      $display("FAIL timeout act=running req=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=0x%0h req=0x%0h", name, act, exp);
      end
   endtask

   // One sample tick with line value v, then gap-1 quiet clocks.
   task automatic tick(input logic v, input int gap);
      @(negedge clk);
      rx_in = v;
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      for (int i = 1; i < gap; i++) @(negedge clk);
   endtask

   function automatic logic line_bit(input logic [7:0] d, input logic par,
                                     input logic stp, input int k);
      int b;
      b = k / 16;
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
`ifdef UART_RX_PARITY_EN
      if (b == 9) return par;
`endif
      return stp;
   endfunction

   task automatic send(input logic [7:0] d, input logic par, input logic stp, input int gap);
      for (int k = 0; k < FRAME_TICKS; k++) tick(line_bit(d, par, stp, k), gap);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 2);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stp;
      int         gap;
      int         exp_valid;
      logic [7:0] exp_data;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[5];
   int   t_a;

   initial begin
      rst = 1'b1;
      sample_tick = 1'b0;
      rx_in = 1'b1;

      vecs[0] = '{8'hA5, 1'b1, 4, 1, 8'hA5, 1'b0};
      vecs[1] = '{8'h3C, 1'b0, 2, 0, 8'hA5, 1'b1};
      vecs[2] = '{8'h81, 1'b1, 3, 1, 8'h81, 1'b0};
      vecs[3] = '{8'h00, 1'b1, 1, 1, 8'h00, 1'b0};
      vecs[4] = '{8'hFF, 1'b1, 1, 1, 8'hFF, 1'b0};

      repeat (3) @(negedge clk);
      check("reset_data", rx_data, 0);
      check("reset_valid", rx_valid, 0);
      check("reset_busy", rx_busy, 0);
      check("reset_ferr", frame_err, 0);
      check("reset_perr", parity_err, 0);
      rst = 1'b0;
      idle(4);

      for (int v = 0; v < 5; v++) begin
         valid_cnt = 0;
         send(vecs[v].data, ^vecs[v].data, vecs[v].stp, vecs[v].gap);
         idle(4);
         check($sformatf("vec%0d_valid_cnt", v), valid_cnt, vecs[v].exp_valid);
         check($sformatf("vec%0d_data", v), rx_data, vecs[v].exp_data);
         check($sformatf("vec%0d_ferr", v), frame_err, vecs[v].exp_ferr);
         check($sformatf("vec%0d_busy", v), rx_busy, 0);
      end

      // Start glitch: low 3 ticks, rejected at the t8 mid-start check.
      valid_cnt = 0;
      for (int k = 0; k < 3; k++) tick(1'b0, 2);
      tick(1'b1, 2);
      tick(1'b1, 2);
      check("glitch_busy_t4", rx_busy, 1);
      tick(1'b1, 2);
      tick(1'b1, 2);
      tick(1'b1, 2);
      check("glitch_busy_t7", rx_busy, 1);
      tick(1'b1, 2);
      check("glitch_busy_t8", rx_busy, 0);
      idle(4);
      check("glitch_valid_cnt", valid_cnt, 0);
      check("glitch_ferr", frame_err, 0);

      // Bad stop then break: no re-trigger while low, then a good frame.
      valid_cnt = 0;
      send(8'h3C, ^8'h3C, 1'b0, 2);
      for (int k = 0; k < 40; k++) tick(1'b0, 2);
      check("break_busy", rx_busy, 1);
      check("break_ferr", frame_err, 1);
      check("break_valid_cnt", valid_cnt, 0);
      check("break_data_held", rx_data, 8'hFF);
      idle(2);
      check("break_recover_idle", rx_busy, 0);
      idle(2);
      send(8'h81, ^8'h81, 1'b1, 2);
      idle(4);
      check("after_break_valid_cnt", valid_cnt, 1);
      check("after_break_data", rx_data, 8'h81);
      check("after_break_ferr", frame_err, 0);

      // Back-to-back frames, ticks every clock, no idle gap.
      valid_cnt = 0;
      send(8'h00, 1'b0, 1'b1, 1);
      t_a = last_tick;
      check("b2b_first_data", rx_data, 8'h00);
      send(8'hFF, 1'b0, 1'b1, 1);
      idle(4);
      check("b2b_valid_cnt", valid_cnt, 2);
      check("b2b_spacing", last_tick - t_a, FRAME_TICKS);
      check("b2b_second_data", rx_data, 8'hFF);

      // Reset in the middle of a frame, including a tick during reset.
      valid_cnt = 0;
      for (int k = 0; k < 70; k++) tick(line_bit(8'h55, 1'b0, 1'b1, k), 2);
      check("midframe_busy", rx_busy, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_data", rx_data, 0);
      check("rst_busy", rx_busy, 0);
      check("rst_valid", rx_valid, 0);
      tick(1'b0, 2);
      check("rst_tick_busy", rx_busy, 0);
      rst = 1'b0;
      idle(4);
      check("rst_release_busy", rx_busy, 0);
      send(8'h12, ^8'h12, 1'b1, 2);
      idle(4);
      check("post_rst_valid_cnt", valid_cnt, 1);
      check("post_rst_data", rx_data, 8'h12);

`ifdef UART_RX_PARITY_EN
      valid_cnt = 0;
      send(8'h07, 1'b0, 1'b1, 2);
      idle(4);
      check("par_bad_valid_cnt", valid_cnt, 0);
      check("par_bad_perr", parity_err, 1);
      check("par_bad_data_held", rx_data, 8'h12);
      check("par_bad_ferr", frame_err, 0);
      send(8'h07, 1'b1, 1'b1, 2);
      idle(4);
      check("par_ok_valid_cnt", valid_cnt, 1);
      check("par_ok_perr", parity_err, 0);
      check("par_ok_data", rx_data, 8'h07);
`else
      check("parity_err_tied", parity_err, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
